uart8_rx_fifo: RTL and testbench
================================

# uart8_rx_fifo

Receive-side byte buffer that sits directly downstream of the 8-bit UART receiver, in the same 16x-oversampled rx clock domain. It converts the receiver's baud-interval-long `done` level into single push events, stores bytes in a parameterised FIFO, and presents them to the host through a first-word-fall-through valid/ready interface. It also keeps a sticky overflow flag and a saturating count of receiver error events, so no byte is lost to the receiver's one-baud-interval output window.

## Interface
- `DEPTH`, 8: number of byte entries; must be a power of 2 and at least 2.
- `ADDR_W`, 3: log2(`DEPTH`).

- `clk`  in  1  rx sampling clock (16x baud), shared with the receiver.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  block enable; low flushes the FIFO.
- `rx_done`  in  1  receiver `done` level (high for about one baud interval).
- `rx_err`  in  1  receiver `err` level.
- `rx_data`  in  8  receiver `out` byte; valid while `rx_done` is high.
- `rd_ready`  in  1  consumer accepts the head byte.
- `clr_status`  in  1  single-cycle clear of `overflow` and `err_count`.
- `rd_valid`  out  1  FIFO non-empty; the head byte is on `rd_data`.
- `rd_data`  out  8  head byte; 8'h00 when empty.
- `count`  out  ADDR_W+1  number of entries held.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `err_count`  out  8  saturating count of `rx_err` rising edges.

## Operation
- **Edge detection.** Registers `done_q` and `err_q` sample `rx_done` and `rx_err` every cycle, regardless of `en`.
  - Push event: `rx_done & !done_q`. Exactly one push per receiver `done` pulse, however long the pulse lasts.
  - Error event: `rx_err & !err_q`.
- **Storage.** `DEPTH` x 8 register array. Write pointer `wp` and read pointer `rp` are each ADDR_W+1 bits and wrap naturally.
  - `count = wp - rp`, modulo 2^(ADDR_W+1).
  - `full` and `empty` are derived from `count`.
- **Push** (event and `en`):
  - If not full, or if a pop happens in the same cycle: write `rx_data` at `mem[wp[ADDR_W-1:0]]` and increment `wp`.
  - If full with no pop: drop the byte, leave `wp` unchanged, set `overflow`.
- **Pop.** When `rd_valid & rd_ready`, increment `rp`. `rd_ready` while empty has no effect.
- **Output.** `rd_data = empty ? 8'h00 : mem[rp[ADDR_W-1:0]]`, driven combinationally from the register array (FWFT). `rd_valid = !empty`.
- **Error events.** Increment `err_count` on each error event, saturating at 255. Events are counted even while `en` is low. No FIFO entry is created for an error event.
- **`clr_status`.**
  - Clears `overflow` and `err_count` on the next edge.
  - If an overflow or error event occurs in the same cycle, the set or increment wins: `overflow` becomes 1, and `err_count` becomes 1.
- **`en` low.**
  - Synchronously resets `wp` and `rp` to 0 and ignores pushes.
  - `done_q` and `err_q` keep tracking their inputs, so raising `en` mid-pulse does not create a false push.
  - `overflow` and `err_count` are retained.

## Timing
- **Reset values.** While `rst_n` is low:
  - `rd_valid=0`, `rd_data=8'h00`, `count=0`, `empty=1`, `full=0`, `overflow=0`, `err_count=0`.
  - `wp`, `rp`, `done_q` and `err_q` are 0.
  - Storage contents are don't-care.
- **Reset release during a `done` pulse.** If `rst_n` is released while `rx_done` is already high, a push occurs on the first edge after release. This is accepted behaviour.
- **Push latency.** Let edge N be the first edge at which `rx_done` is sampled high. The byte is written at edge N. `rd_valid` and `rd_data` reflect it after edge N, i.e. one cycle of latency.
- **Pop latency.** A pop at edge M exposes the next entry, or empty, immediately after M. Sustained throughput is 1 byte per clock.
- **Simultaneous push and pop.**
  - When empty: the push lands and `rd_valid` rises; the pop is ignored.
  - When full: both are accepted; `count` stays at `DEPTH` and there is no overflow.
- **Wrap-around.** Pointers wrap from 2^(ADDR_W+1)-1 to 0 with no discontinuity in `count`.
- **`rst_n` mid-transfer.** Asynchronous clear of all state; no partial entries remain.

## Test plan
- **Single byte.** Hold `rx_done=1` for 16 cycles with `rx_data=8'hA5`, `rd_ready=0` -> `count=1`, `rd_valid=1`, `rd_data=8'hA5` from the cycle after the rising edge; still only 1 entry after the pulse ends. Then pulse `rd_ready` -> `empty=1`, `rd_data=8'h00`.
- **Fill and overflow.** 9 `done` pulses carrying 8'h01..8'h09, `DEPTH=8`, `rd_ready=0` -> `full=1`, `count=8`, `overflow=1`. Reading all 8 yields 8'h01..8'h08 in order; 8'h09 is absent. Then `clr_status` -> `overflow=0`.
- **Full with simultaneous push and pop.** Full FIFO, `rd_ready=1` on the push cycle -> `count` stays 8, `overflow=0`, head advances to 8'h02, and the tail holds the new byte.
- **Wrap-around.** Stream 40 bytes through with randomised `rd_ready` -> output matches the input order exactly and `count` never exceeds 8.
- **Error counting.** 3 `rx_err` pulses -> `err_count=3` with no FIFO entries created. Then 300 pulses -> `err_count=255`. Then `clr_status` coinciding with an error rising edge -> `err_count=1`.
- **Enable and reset.** Drop `en` with 4 entries held -> `count=0` next cycle and `overflow` is retained. Raise `en` while `rx_done` is already high -> no push. Assert `rst_n=0` asynchronously mid-stream -> all outputs take their reset values immediately.

Source files
------------

// File: rtl/uart8_rx_fifo.sv
// uart8_rx_fifo: FWFT byte buffer behind the 8-bit UART receiver.
// Turns done pulses into pushes, tracks overflow and rx error events.
module uart8_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              rx_done,
  input  logic              rx_err,
  input  logic [7:0]        rx_data,
  input  logic              rd_ready,
  input  logic              clr_status,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W:0] FULL_CNT =
    (ADDR_W+1)'(DEPTH);

  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wp;
  logic [ADDR_W:0] rp;
  logic            done_q;
  logic            err_q;
  logic            push_ev;
  logic            err_ev;
  logic            pop;
  logic            push;
  logic            drop;

  assign push_ev = rx_done & ~done_q;
  assign err_ev  = rx_err & ~err_q;

  assign count    = wp - rp;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign rd_valid = ~empty;
  assign rd_data  = empty ? 8'h00
                          : mem[rp[ADDR_W-1:0]];

  assign pop  = en & rd_valid & rd_ready;
  assign push = en & push_ev & (~full | pop);
  assign drop = en & push_ev & full & ~pop;

  // Edge detectors track inputs even when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= rx_done;
      err_q  <= rx_err;
    end
  end

  // Pointers: flushed while disabled, else advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (!en) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // Byte storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wp[ADDR_W-1:0]] <= rx_data;
  end

  // Sticky overflow; a new drop beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_status) begin
      overflow <= 1'b0;
    end
  end

  // Saturating error counter; event beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (err_ev && clr_status) begin
      err_count <= 8'd1;
    end else if (err_ev) begin
      if (err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end else if (clr_status) begin
      err_count <= 8'd0;
    end
  end

endmodule

// File: tb/tb_uart8_rx_fifo.sv
// tb_uart8_rx_fifo: directed checks for uart8_rx_fifo.
// Table-driven single-byte run plus multi-cycle sequences.
module tb_uart8_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rx_done;
  logic       rx_err;
  logic [7:0] rx_data;
  logic       rd_ready;
  logic       clr_status;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] err_count;

  int total;
  int passed;

  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [3:0] exp_count;
  } vec_t;

  vec_t tbl [19];

  int   q [$];
  int   sent;
  int   recv;
  int   cyc;
  int   phase;
  logic pd;
  logic d;
  logic pp;
  logic [7:0] exp_b [8];

  uart8_rx_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .rx_done    (rx_done),
    .rx_err     (rx_err),
    .rx_data    (rx_data),
    .rd_ready   (rd_ready),
    .clr_status (clr_status),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    step();
    rx_done = 1'b0;
    step();
  endtask

  task automatic read_one();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  task automatic err_pulse();
    rx_err = 1'b1;
    step();
    rx_err = 1'b0;
    step();
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst_n = 1'b0;
    en = 1'b1;
    rx_done = 1'b0;
    rx_err = 1'b0;
    rx_data = 8'h00;
    rd_ready = 1'b0;
    clr_status = 1'b0;

    // single-byte table: 16-cycle done pulse, then a pop
    for (int i = 0; i < 19; i++) begin
      tbl[i].done      = (i < 16);
      tbl[i].data      = 8'hA5;
      tbl[i].rdy       = (i == 17);
      tbl[i].exp_valid = (i < 17);
      tbl[i].exp_data  = (i < 17) ? 8'hA5 : 8'h00;
      tbl[i].exp_count = (i < 17) ? 4'd1 : 4'd0;
    end

    #12;
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", err_count, 0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 19; i++) begin
      rx_done  = tbl[i].done;
      rx_data  = tbl[i].data;
      rd_ready = tbl[i].rdy;
      step();
      chk($sformatf("single_valid[%0d]", i),
          rd_valid, tbl[i].exp_valid);
      chk($sformatf("single_data[%0d]", i),
          rd_data, tbl[i].exp_data);
      chk($sformatf("single_count[%0d]", i),
          count, tbl[i].exp_count);
    end
    rd_ready = 1'b0;

    // fill and overflow
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    chk("fill_ovf", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("fill_rd[%0d]", i), rd_data, i);
      read_one();
    end
    chk("fill_empty", empty, 1);
    chk("fill_rd_data0", rd_data, 0);
    chk("fill_ovf_kept", overflow, 1);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("clr_ovf", overflow, 0);

    // full with simultaneous push and pop
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    chk("fp_full", full, 1);
    rx_data  = 8'hAA;
    rx_done  = 1'b1;
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("fp_count", count, 8);
    chk("fp_ovf", overflow, 0);
    chk("fp_head", rd_data, 8'h02);
    step();
    rx_done = 1'b0;
    step();
    for (int i = 0; i < 7; i++) exp_b[i] = 8'(i + 2);
    exp_b[7] = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fp_rd[%0d]", i), rd_data, exp_b[i]);
      read_one();
    end
    chk("fp_empty", empty, 1);

    // wrap-around stream against a queue model
    sent = 0;
    recv = 0;
    cyc = 0;
    phase = 0;
    pd = 1'b0;
    while (recv < 40 && cyc < 800) begin
      d = (sent < 40) && (phase != 2);
      rx_done  = d;
      rx_data  = 8'(8'h40 + sent);
      rd_ready = ($urandom_range(0, 3) != 0);
      pp = (q.size() > 0) && rd_ready;
      if (pp) begin
        chk("wrap_data", rd_data, q[0]);
        void'(q.pop_front());
        recv++;
      end
      if (d && !pd && q.size() < 8) q.push_back(int'(rx_data));
      pd = d;
      step();
      chk("wrap_count", count, q.size());
      cyc++;
      if (sent < 40) begin
        if (phase == 2) begin
          phase = 0;
          sent++;
        end else begin
          phase++;
        end
      end
    end
    rx_done = 1'b0;
    rd_ready = 1'b0;
    chk("wrap_recv", recv, 40);
    chk("wrap_ovf", overflow, 0);
    step();

    // enable low flushes, overflow retained
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    for (int i = 0; i < 4; i++) read_one();
    chk("en_count4", count, 4);
    chk("en_ovf_set", overflow, 1);
    en = 1'b0;
    step();
    chk("en_flush", count, 0);
    chk("en_ovf_kept", overflow, 1);
    chk("en_empty", empty, 1);
    rx_data = 8'h55;
    rx_done = 1'b1;
    step();
    step();
    chk("en_off_nopush", count, 0);
    en = 1'b1;
    step();
    step();
    chk("en_mid_pulse", count, 0);
    rx_done = 1'b0;
    step();
    chk("en_after", count, 0);

    // error counting
    for (int i = 0; i < 3; i++) err_pulse();
    chk("err3", err_count, 3);
    chk("err_nofifo", count, 0);
    for (int i = 0; i < 300; i++) err_pulse();
    chk("err_sat", err_count, 255);
    rx_err = 1'b1;
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    rx_err = 1'b0;
    chk("err_clr_evt", err_count, 1);
    chk("err_clr_ovf", overflow, 0);
    step();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("err_clr", err_count, 0);
    err_pulse();

    // asynchronous reset mid-stream
    send_byte(8'h11);
    send_byte(8'h22);
    chk("ar_count", count, 2);
    chk("ar_err", err_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", rd_valid, 0);
    chk("ar_data", rd_data, 0);
    chk("ar_count0", count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_full", full, 0);
    chk("ar_err0", err_count, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_post_empty", empty, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
